// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: rebuilds h/v counts,
// tracks lock, flags faults and captures one probed pixel.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int WDOG        = 1600
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        blank_n_i,
  input  logic [23:0] rgb_i,
  input  logic [9:0]  probe_x_i,
  input  logic [9:0]  probe_y_i,
  input  logic        err_clr_i,
  output logic        locked_o,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic [9:0]  h_meas_o,
  output logic [9:0]  v_meas_o,
  output logic [15:0] frame_cnt_o,
  output logic [23:0] probe_rgb_o,
  output logic        probe_valid_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  localparam int WDW = (WDOG > 2) ? $clog2(WDOG) : 1;
  localparam logic [9:0] HT = 10'(H_TOTAL);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  localparam logic [WDW-1:0] WD_MAX = WDW'(WDOG - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic        hs_q, hs_qq, vs_q, vs_qq, blank_q;
  logic [23:0] rgb_q;
  logic        hs_fall, vs_fall;

  logic [9:0]  hcnt, acnt, vcnt, lines_act, ycnt;
  logic        line_valid, frame_bad, probe_done;
  logic [WDW-1:0] wd;

  state_t      state, state_d;
  logic [3:0]  good, good_d;
  logic [2:0]  err_set;

  logic [9:0]  h_len, vcnt_n, lines_act_n;
  logic        act_line, line_bad, frame_bad_n;
  logic        frame_ok, wd_trip, hit;

  // Sample the pins, then register the sync falls one more stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q    <= 1'b0;
      hs_qq   <= 1'b0;
      vs_q    <= 1'b0;
      vs_qq   <= 1'b0;
      blank_q <= 1'b0;
      rgb_q   <= '0;
      hs_fall <= 1'b0;
      vs_fall <= 1'b0;
    end else begin
      hs_q    <= hs_i;
      hs_qq   <= hs_q;
      vs_q    <= vs_i;
      vs_qq   <= vs_q;
      blank_q <= blank_n_i;
      rgb_q   <= rgb_i;
      hs_fall <= ~hs_q & hs_qq;
      vs_fall <= ~vs_q & vs_qq;
    end
  end

  // Line/frame figures as they stand once the current line closes
  always_comb begin
    h_len       = sat_inc(hcnt);
    act_line    = hs_fall & (acnt == HA);
    line_bad    = hs_fall & line_valid &
                  ((h_len != HT) | ((acnt != 10'd0) & (acnt != HA)));
    vcnt_n      = hs_fall ? sat_inc(vcnt) : vcnt;
    lines_act_n = act_line ? sat_inc(lines_act) : lines_act;
    frame_bad_n = frame_bad | line_bad;
    frame_ok    = ~frame_bad_n & (vcnt_n == VT) & (lines_act_n == VA);
    wd_trip     = (state != SEARCH) & ~hs_fall & (wd == WD_MAX);
    hit         = blank_q & ~probe_done &
                  (acnt == probe_x_i) & (ycnt == probe_y_i);
  end

  // Horizontal counters and line-length measurement
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt       <= '0;
      acnt       <= '0;
      line_valid <= 1'b0;
      h_meas_o   <= '0;
    end else begin
      if (hs_fall) begin
        hcnt <= '0;
        acnt <= {9'd0, blank_q};
        if (line_valid) h_meas_o <= h_len;
      end else begin
        hcnt <= sat_inc(hcnt);
        if (blank_q) acnt <= sat_inc(acnt);
      end
      if (wd_trip) line_valid <= 1'b0;
      else if (hs_fall) line_valid <= 1'b1;
    end
  end

  // Vertical counters, frame-height measurement and frame count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vcnt        <= '0;
      lines_act   <= '0;
      frame_bad   <= 1'b0;
      ycnt        <= '0;
      v_meas_o    <= '0;
      frame_cnt_o <= '0;
    end else if (vs_fall) begin
      vcnt      <= '0;
      lines_act <= '0;
      frame_bad <= 1'b0;
      ycnt      <= '0;
      v_meas_o  <= vcnt_n;
      if (state != SEARCH) frame_cnt_o <= frame_cnt_o + 16'd1;
    end else begin
      vcnt      <= vcnt_n;
      lines_act <= lines_act_n;
      frame_bad <= frame_bad_n;
      if (act_line) ycnt <= sat_inc(ycnt);
    end
  end

  // Active-pixel coordinates and the single-pixel probe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_o           <= '0;
      y_o           <= '0;
      probe_rgb_o   <= '0;
      probe_valid_o <= 1'b0;
      probe_done    <= 1'b0;
    end else begin
      if (blank_q) begin
        x_o <= acnt;
        y_o <= ycnt;
      end
      probe_valid_o <= hit;
      if (hit) probe_rgb_o <= rgb_q;
      if (vs_fall) probe_done <= 1'b0;
      else if (hit) probe_done <= 1'b1;
    end
  end

  // Clocks since the last hs fall, idle while searching
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd <= '0;
    end else if ((state == SEARCH) | hs_fall) begin
      wd <= '0;
    end else if (wd != WD_MAX) begin
      wd <= wd + 1'b1;
    end
  end

  // FSM state and clean-frame counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_d;
      good  <= good_d;
    end
  end

  // FSM next state and fault causes
  always_comb begin
    state_d = state;
    good_d  = good;
    err_set = 3'b000;
    unique case (1'b1)
      (state == SEARCH): begin
        good_d = '0;
        if (vs_fall) state_d = MEASURE;
      end
      (state == MEASURE): begin
        if (vs_fall) begin
          if (!frame_ok) begin
            good_d = '0;
          end else if (good + 4'd1 >= LF) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good + 4'd1;
          end
        end
      end
      (state == LOCKED): begin
        if (line_bad | (vs_fall & ~frame_ok)) begin
          state_d    = MEASURE;
          good_d     = '0;
          err_set[0] = line_bad;
          err_set[1] = vs_fall &
                       ((vcnt_n != VT) | (lines_act_n != VA));
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
    if (wd_trip) begin
      state_d    = SEARCH;
      good_d     = '0;
      err_set[2] = 1'b1;
    end
  end

  // FSM output
  always_comb begin
    locked_o = (state == LOCKED);
  end

  // Sticky fault flags; a new fault beats a clear in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      err_o      <= (err_clr_i ? 1'b0 : err_o) | (|err_set);
      err_code_o <= (err_clr_i ? 3'b000 : err_code_o) | err_set;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down raster:
// lock, line/frame faults, watchdog, probe and reset.
module tb_vga_sync_monitor;

  localparam int HT   = 40;
  localparam int HA   = 24;
  localparam int VT   = 20;
  localparam int VA   = 12;
  localparam int LF   = 2;
  localparam int WD   = 80;
  localparam int HS_W = 4;
  localparam int H_AS = 8;
  localparam int V_SW = 2;
  localparam int V_AS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_i = 1'b1;
  logic        vs_i = 1'b1;
  logic        blank_n_i = 1'b0;
  logic [23:0] rgb_i = '0;
  logic [9:0]  probe_x = '0;
  logic [9:0]  probe_y = '0;
  logic        err_clr_i = 1'b0;
  logic        locked_o;
  logic [9:0]  x_o, y_o, h_meas_o, v_meas_o;
  logic [15:0] frame_cnt_o;
  logic [23:0] probe_rgb_o;
  logic        probe_valid_o;
  logic        err_o;
  logic [2:0]  err_code_o;

  vga_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA),
    .V_ACTIVE(VA), .LOCK_FRAMES(LF), .WDOG(WD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .hs_i(hs_i), .vs_i(vs_i),
    .blank_n_i(blank_n_i), .rgb_i(rgb_i),
    .probe_x_i(probe_x), .probe_y_i(probe_y),
    .err_clr_i(err_clr_i),
    .locked_o(locked_o),
    .x_o(x_o), .y_o(y_o),
    .h_meas_o(h_meas_o), .v_meas_o(v_meas_o),
    .frame_cnt_o(frame_cnt_o),
    .probe_rgb_o(probe_rgb_o),
    .probe_valid_o(probe_valid_o),
    .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int          at;
    logic [23:0] rgb;
  } probe_exp_t;

  probe_exp_t sb[$];
  int pushes = 0;
  int pulses = 0;

  logic lk_prev = 1'b0;
  int   lk_cyc  = -1;

  // Lock edges and probe pulses, sampled on the falling edge
  always @(negedge clk) begin
    probe_exp_t e;
    if (locked_o !== lk_prev) begin
      lk_prev = locked_o;
      lk_cyc  = cyc;
    end
    if (probe_valid_o) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("probe_spur", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("probe_rgb", probe_rgb_o, e.rgb);
        chk("probe_cyc", cyc, e.at);
      end
    end
  end

  int vs_k = 0;
  int bad_k = 0;
  int last_hs_k = 0;

  task automatic frame(input int lines,
                       input int stretch,
                       input int clr_line);
    int len, x, y;
    logic act;
    logic [23:0] c;
    for (int l = 0; l < lines; l++) begin
      len = (l == stretch) ? HT + 1 : HT;
      for (int p = 0; p < len; p++) begin
        x = p - H_AS;
        y = l - V_AS;
        act = (y >= 0) && (y < VA) && (x >= 0) && (x < HA);
        c = {x[7:0], y[7:0], 8'hA5};
        @(negedge clk);
        if (p == 0) begin
          if (l == 0) vs_k = cyc + 1;
          if (l == stretch + 1) bad_k = cyc + 1;
          last_hs_k = cyc + 1;
        end
        if (act && x == int'(probe_x) && y == int'(probe_y)) begin
          sb.push_back('{cyc + 2, c});
          pushes++;
        end
        hs_i      = (p >= HS_W);
        vs_i      = (l >= V_SW);
        blank_n_i = act;
        rgb_i     = act ? c : 24'h0;
        err_clr_i = (l == clr_line) && (p == 20);
      end
    end
  endtask

  task automatic hold(input int n, input int clr_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs_i      = 1'b1;
      vs_i      = 1'b1;
      blank_n_i = 1'b0;
      rgb_i     = '0;
      err_clr_i = (cyc + 1 == clr_at);
    end
    @(negedge clk);
    err_clr_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked_o, 0);
    chk({tag, "_fcnt"}, frame_cnt_o, 0);
    chk({tag, "_hmeas"}, h_meas_o, 0);
    chk({tag, "_vmeas"}, v_meas_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_code"}, err_code_o, 0);
    chk({tag, "_x"}, x_o, 0);
    chk({tag, "_y"}, y_o, 0);
    chk({tag, "_prgb"}, probe_rgb_o, 0);
    chk({tag, "_pval"}, probe_valid_o, 0);
  endtask

  int t_wd;
  int fc;

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    hold(5, -1);

    // nominal stream, lock at 3rd vs fall
    frame(VT, -1, -1);
    frame(VT, -1, -1);
    chk("pre_lock", locked_o, 0);
    frame(VT, -1, -1);
    chk("lock", locked_o, 1);
    chk("lock_lat", lk_cyc, vs_k + 2);
    chk("h_meas", h_meas_o, HT);
    chk("v_meas", v_meas_o, VT);
    chk("nom_err", err_o, 0);
    chk("fcnt3", frame_cnt_o, 2);
    chk("x_hold", x_o, HA - 1);
    chk("y_hold", y_o, VA - 1);

    // one line one clock long
    frame(VT, 5, -1);
    chk("long_unlock", locked_o, 0);
    chk("long_lat", lk_cyc, bad_k + 2);
    chk("long_code", err_code_o, 3'b001);
    chk("long_err", err_o, 1);
    frame(VT, -1, -1);
    frame(VT, -1, -1);
    chk("long_nolock", locked_o, 0);
    frame(VT, -1, 2);
    chk("relock1", locked_o, 1);
    chk("relock1_lat", lk_cyc, vs_k + 2);
    chk("clr_err", err_o, 0);
    chk("clr_code", err_code_o, 0);

    // other probe positions
    probe_x = 10'(HA - 1);
    probe_y = 10'(VA - 1);
    frame(VT, -1, -1);
    chk("sb_drain1", sb.size(), 0);
    probe_x = 10'(HA / 2);
    probe_y = 10'(VA / 2);
    frame(VT, -1, -1);
    chk("sb_drain2", sb.size(), 0);

    // one frame a line short
    frame(VT - 1, -1, -1);
    frame(VT, -1, -1);
    chk("short_unlock", locked_o, 0);
    chk("short_lat", lk_cyc, vs_k + 2);
    chk("short_vmeas", v_meas_o, VT - 1);
    chk("short_code", err_code_o, 3'b010);
    frame(VT, -1, -1);
    chk("short_nolock", locked_o, 0);
    frame(VT, -1, -1);
    chk("relock2", locked_o, 1);
    chk("relock2_lat", lk_cyc, vs_k + 2);
    chk("relock2_vmeas", v_meas_o, VT);
    chk("fcnt13", frame_cnt_o, 12);

    // hs stalls; clear lands on the trip cycle
    frame(VT, -1, 1);
    chk("pre_wd_err", err_o, 0);
    t_wd = last_hs_k + 2 + WD;
    hold(WD + 20, t_wd);
    chk("wd_unlock", locked_o, 0);
    chk("wd_lat", lk_cyc, t_wd);
    chk("wd_code", err_code_o, 3'b100);
    chk("wd_err", err_o, 1);
    fc = int'(frame_cnt_o);
    frame(VT, -1, -1);
    chk("wd_search", frame_cnt_o, fc);
    frame(VT, -1, -1);
    frame(VT, -1, -1);
    chk("wd_relock", locked_o, 1);
    chk("wd_relock_lat", lk_cyc, vs_k + 2);
    chk("wd_fcnt", frame_cnt_o, fc + 2);

    // reset mid-line while locked
    frame(3, -1, -1);
    hold(15, -1);
    chk("prerst_err", err_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(5, -1);
    frame(VT, -1, -1);
    frame(VT, -1, -1);
    chk("rst_nolock", locked_o, 0);
    frame(VT, -1, -1);
    chk("rst_relock", locked_o, 1);
    chk("rst_relock_lat", lk_cyc, vs_k + 2);
    chk("rst_fcnt", frame_cnt_o, 2);

    hold(5, -1);
    chk("sb_final", sb.size(), 0);
    chk("probe_count", pulses, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side checker for the 640x480@60 VGA stream that the display path drives. It sits on the pixel clock beside the VGA output pins. It samples the outgoing sync, blank and RGB signals and rebuilds the horizontal and vertical counts. It declares lock once it has seen consecutive clean frames, flags timing faults, and captures the RGB value at one programmable coordinate so the bench and SignalTap can check rendered symbols without a monitor.

## Interface
- H_TOTAL, 800, expected pixel clocks per line
- V_TOTAL, 525, expected lines per frame
- H_ACTIVE, 640, expected blank_n-high pixels per active line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required for lock (1..15)
- WDOG, 1600, pixel clocks without an hs falling edge before the watchdog trips
- clk_i  in  1  pixel clock (25 MHz); the only clock
- rst_ni  in  1  asynchronous active-low reset
- hs_i  in  1  horizontal sync, active low
- vs_i  in  1  vertical sync, active low
- blank_n_i  in  1  high during active video
- rgb_i  in  24  {R,G,B} pixel data
- probe_x_i  in  10  capture column (0..H_ACTIVE-1)
- probe_y_i  in  10  capture row (0..V_ACTIVE-1)
- err_clr_i  in  1  single-cycle pulse that clears err_o and err_code_o
- locked_o  out  1  timing matches the parameters
- x_o, y_o  out  10 each  coordinate of the current active pixel
- h_meas_o, v_meas_o  out  10 each  last measured line length and frame height (saturating)
- frame_cnt_o  out  16  completed frames since reset; wraps
- probe_rgb_o  out  24  last captured pixel
- probe_valid_o  out  1  one-cycle pulse when probe_rgb_o updates
- err_o  out  1  sticky fault flag
- err_code_o  out  3  sticky cause bits: [0] line length, [1] frame height, [2] watchdog

## Operation
- Input stage:
  - hs_i, vs_i, blank_n_i and rgb_i are registered once (_q); hs and vs are registered a second time for edge detection.
  - hs_fall = hs_q low & previous high. vs_fall is defined the same way.
- Horizontal counter:
  - hcnt increments every clock and saturates at 1023.
  - On hs_fall: h_meas_o <= hcnt+1 and hcnt <= 0.
  - The first hs_fall after reset or after entering SEARCH only sets line_valid; it does not measure.
- Line checks:
  - acnt counts blank_n_q-high clocks in the line.
  - On hs_fall, line_bad is set if h_meas ≠ H_TOTAL, or if acnt is neither 0 nor H_ACTIVE.
- Vertical counter:
  - vcnt counts hs_fall and saturates at 1023.
  - On vs_fall: v_meas_o <= vcnt and vcnt <= 0.
  - lines_act counts lines with acnt = H_ACTIVE.
- Coordinates:
  - x_o = acnt, taken when blank_n_q is high.
  - y_o = number of active lines completed since vs_fall.
  - Both hold their values while blanked.
- Probe:
  - When blank_n_q & x = probe_x_i & y = probe_y_i: probe_rgb_o <= rgb_q and probe_valid_o pulses.
  - This happens at most once per frame.
- FSM states:
  - SEARCH: reset state. Moves to MEASURE on the first vs_fall. good = 0.
  - MEASURE: on each vs_fall, the frame is clean if no line_bad occurred, vcnt = V_TOTAL and lines_act = V_ACTIVE.
    - Clean frame: good++. When good reaches LOCK_FRAMES, go to LOCKED.
    - Dirty frame: good = 0.
  - LOCKED: a line_bad or a dirty vs_fall drops lock immediately, sets the matching err_code bit, sets err_o, goes to MEASURE and clears good.
- Watchdog: WDOG clocks without hs_fall in any state except SEARCH sets err_code[2], drops lock and goes to SEARCH.
- frame_cnt_o increments on every vs_fall outside SEARCH.
- Error flags:
  - err_o and err_code_o are set only from LOCKED or by the watchdog.
  - err_clr_i clears them. If a set and err_clr_i occur in the same cycle, the set wins.

## Timing
- Reset values: every output is 0, the FSM is in SEARCH, and every counter is 0.
- Asynchronous reset mid-frame returns to SEARCH. Lock then requires LOCKED_FRAMES+1 vs_falls again.
- Latency: a sync edge sampled at clock edge k produces the matching register update at edge k+2. This covers h_meas_o, v_meas_o, locked_o and frame_cnt_o.
- Probe: probe_valid_o rises 2 clocks after the probed pixel is presented on rgb_i. probe_rgb_o is valid in the same cycle.
- Simultaneous hs_fall and vs_fall: the line is closed and counted first, then the frame is evaluated using the updated vcnt.
- Measurement counters saturate at 1023 and never wrap. A saturated value is always a mismatch.

## Test plan
- Nominal 800x525 stream, LOCK_FRAMES=2 → locked_o rises 2 clocks after the 3rd vs_fall. h_meas_o=800, v_meas_o=525, err_o=0.
- Locked; one line stretched to 801 clocks → locked_o falls 2 clocks after that line's hs_fall. err_code_o=3'b001. Relock after 2 clean frames.
- Locked; hs_i held high for 1700 clocks → err_code_o[2]=1, FSM in SEARCH, locked_o=0. A simultaneous err_clr_i does not clear the flag.
- probe = (0,0), (639,479) and (320,240) with rgb_i = {x[7:0], y[7:0], 8'hA5} → one probe_valid_o pulse per frame, carrying the matching value.
- Frame with 524 lines → v_meas_o=524 and good resets. Lock is reached only after 2 further clean frames.
- rst_ni asserted mid-line while locked → all outputs 0 immediately. After release, lock returns at the 3rd vs_fall.
